secuenciador_ops: RTL and testbench

SECUENCIADOR_OPS -- requirements
Module: secuenciador_ops

---
 rtl/secuenciador_pkg.sv | 38 +++
 rtl/fifo_comandos.sv | 74 +++++++
 rtl/secuenciador_ops.sv | 186 ++++++++++++++++++
 tb/tb_secuenciador_ops.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/secuenciador_pkg.sv
// Shared types for the operation sequencer: FSM states, queued command layout, defaults.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package secuenciador_pkg;

    // Default number of command FIFO entries (power of two).
    localparam int FIFO_DEPTH_DEF = 4;

    // Default width of the retired-command counter.
    localparam int COUNT_W_DEF = 8;

    // Sequencer FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    // One queued command, exactly as captured at the input handshake.
    typedef struct packed {
        logic        load;   // 1 = immediate load into rd, 0 = ALU operation
        logic [3:0]  op;     // ALU control code
        logic        flag;   // ALU carry/shift-in
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [15:0] data;   // immediate for loads
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    // Loads have no ALU stage, so they skip EXEC and go straight to WRITE.
    function automatic state_t state_after_fetch(input cmd_t c);
        return c.load ? ST_WRITE : ST_EXEC;
    endfunction

endpackage

// File: rtl/fifo_comandos.sv
// Command FIFO: circular buffer with registered pointers and occupancy count.
// Latency: a pushed entry is visible at the head one cycle after the push edge.
// Backpressure: full_o blocks pushes; push and pop on the same edge both complete.
module fifo_comandos #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_dat_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] pop_dat_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    cnt_q, cnt_d;
    logic              do_push;
    logic              do_pop;

    assign full_o    = (cnt_q == FULL_CNT);
    assign empty_o   = (cnt_q == '0);
    assign pop_dat_o = mem_q[rd_ptr_q];

    // Guard the strobes so a stray push when full or pop when empty cannot corrupt state.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Next-state for storage, pointers and occupancy; depth is a power of two so pointers wrap naturally.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_dat_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // State registers; reset empties the FIFO immediately.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/secuenciador_ops.sv
// Operation sequencer: queues commands and drives register-bank/ALU controls through IDLE/FETCH/EXEC/WRITE.
// Latency: accept at t0 -> FETCH after t1; ALU write after t3, load write after t2; back-to-back 3 (ALU) / 2 (load) cycles.
// Backpressure: cmd_ready_o = command FIFO not full, independent of cmd_valid_i.
module secuenciador_ops
    import secuenciador_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int COUNT_W    = COUNT_W_DEF
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic               cmd_load_i,
    input  logic [3:0]         cmd_op_i,
    input  logic               cmd_flag_i,
    input  logic [4:0]         cmd_rs1_i,
    input  logic [4:0]         cmd_rs2_i,
    input  logic [4:0]         cmd_rd_i,
    input  logic [15:0]        cmd_data_i,
    output logic [4:0]         addr_rs1_o,
    output logic [4:0]         addr_rs2_o,
    output logic [4:0]         addr_rd_o,
    output logic [3:0]         alucont_o,
    output logic               flag_o,
    output logic               mux_o,
    output logic [15:0]        data_o,
    output logic               we_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [COUNT_W-1:0] count_o
);

    cmd_t               cmd_in;
    cmd_t               fifo_head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_push;
    logic               fifo_pop;

    state_t             state_q, state_d;
    cmd_t               cur_q, cur_d;
    logic [COUNT_W-1:0] count_q, count_d;

    logic [4:0]         addr_rs1_q, addr_rs1_d;
    logic [4:0]         addr_rs2_q, addr_rs2_d;
    logic [4:0]         addr_rd_q, addr_rd_d;
    logic [3:0]         alucont_q, alucont_d;
    logic               flag_q, flag_d;
    logic               mux_q, mux_d;
    logic [15:0]        data_q, data_d;
    logic               we_q, we_d;
    logic               done_q, done_d;

    assign cmd_in.load = cmd_load_i;
    assign cmd_in.op   = cmd_op_i;
    assign cmd_in.flag = cmd_flag_i;
    assign cmd_in.rs1  = cmd_rs1_i;
    assign cmd_in.rs2  = cmd_rs2_i;
    assign cmd_in.rd   = cmd_rd_i;
    assign cmd_in.data = cmd_data_i;

    assign cmd_ready_o = !fifo_full;
    assign fifo_push   = cmd_valid_i && !fifo_full;

    fifo_comandos #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (CMD_W)
    ) u_fifo (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .push_i     (fifo_push),
        .push_dat_i (cmd_in),
        .pop_i      (fifo_pop),
        .pop_dat_o  (fifo_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    // FSM next state, head-of-queue pop into the current-command register, and retire counting.
    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        count_d  = count_q;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    cur_d    = fifo_head;
                    state_d  = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_d = state_after_fetch(cur_q);
            end
            ST_EXEC: begin
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                // The command retires as WRITE is left; chain straight into the next one if queued.
                count_d = count_q + 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    cur_d    = fifo_head;
                    state_d  = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered output decode: active states present the current command, IDLE presents all zeros.
    always_comb begin
        addr_rs1_d = '0;
        addr_rs2_d = '0;
        addr_rd_d  = '0;
        alucont_d  = '0;
        flag_d     = 1'b0;
        mux_d      = 1'b0;
        data_d     = '0;
        we_d       = 1'b0;
        done_d     = 1'b0;
        if (state_d != ST_IDLE) begin
            addr_rs1_d = cur_d.rs1;
            addr_rs2_d = cur_d.rs2;
            addr_rd_d  = cur_d.rd;
            alucont_d  = cur_d.op;
            flag_d     = cur_d.flag;
            mux_d      = !cur_d.load;
            data_d     = cur_d.data;
        end
        if (state_d == ST_WRITE) begin
            we_d   = 1'b1;
            done_d = 1'b1;
        end
    end

    // All sequencer state and outputs; reset aborts any command and drops we_o at once.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            cur_q      <= '0;
            count_q    <= '0;
            addr_rs1_q <= '0;
            addr_rs2_q <= '0;
            addr_rd_q  <= '0;
            alucont_q  <= '0;
            flag_q     <= 1'b0;
            mux_q      <= 1'b0;
            data_q     <= '0;
            we_q       <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            count_q    <= count_d;
            addr_rs1_q <= addr_rs1_d;
            addr_rs2_q <= addr_rs2_d;
            addr_rd_q  <= addr_rd_d;
            alucont_q  <= alucont_d;
            flag_q     <= flag_d;
            mux_q      <= mux_d;
            data_q     <= data_d;
            we_q       <= we_d;
            done_q     <= done_d;
        end
    end

    assign addr_rs1_o = addr_rs1_q;
    assign addr_rs2_o = addr_rs2_q;
    assign addr_rd_o  = addr_rd_q;
    assign alucont_o  = alucont_q;
    assign flag_o     = flag_q;
    assign mux_o      = mux_q;
    assign data_o     = data_q;
    assign we_o       = we_q;
    assign done_o     = done_q;
    assign count_o    = count_q;
    assign busy_o     = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_secuenciador_ops.sv
// Bench for secuenciador_ops: directed commands, expected writes queued at accept, monitor compares at each we_o.
// Latency: checks exact write cycle of isolated commands and spacing of back-to-back ones.
// Backpressure: drives cmd_valid_i and honours cmd_ready_o sampled before each edge.
module tb_secuenciador_ops;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_load_i = 1'b0;
    logic [3:0]  cmd_op_i = '0;
    logic        cmd_flag_i = 1'b0;
    logic [4:0]  cmd_rs1_i = '0;
    logic [4:0]  cmd_rs2_i = '0;
    logic [4:0]  cmd_rd_i = '0;
    logic [15:0] cmd_data_i = '0;
    logic [4:0]  addr_rs1_o, addr_rs2_o, addr_rd_o;
    logic [3:0]  alucont_o;
    logic        flag_o, mux_o, we_o, busy_o, done_o;
    logic [15:0] data_o;
    logic [7:0]  count_o;

    secuenciador_ops #(.FIFO_DEPTH(4), .COUNT_W(8)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_load_i  (cmd_load_i),
        .cmd_op_i    (cmd_op_i),
        .cmd_flag_i  (cmd_flag_i),
        .cmd_rs1_i   (cmd_rs1_i),
        .cmd_rs2_i   (cmd_rs2_i),
        .cmd_rd_i    (cmd_rd_i),
        .cmd_data_i  (cmd_data_i),
        .addr_rs1_o  (addr_rs1_o),
        .addr_rs2_o  (addr_rs2_o),
        .addr_rd_o   (addr_rd_o),
        .alucont_o   (alucont_o),
        .flag_o      (flag_o),
        .mux_o       (mux_o),
        .data_o      (data_o),
        .we_o        (we_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .count_o     (count_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  op;
        logic        flag, mux;
        logic [15:0] data;
        int          exp_cyc;   // absolute cycle of the write, -1 = not checked
        int          gap;       // cycles since previous write, 0 = not checked
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
    endtask

    task automatic sync();
        @(posedge clk_i);
        #1;
    endtask

    // Must be entered just after a rising edge; leaves cmd_valid_i high for back-to-back use.
    task automatic send(input logic ld, input logic [3:0] op, input logic fl,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic [15:0] dat, input int rel, input int gap);
        exp_t e;
        bit   acc;
        bit   taken;
        taken = 1'b0;
        cmd_valid_i = 1'b1;
        cmd_load_i = ld;  cmd_op_i = op;   cmd_flag_i = fl;
        cmd_rs1_i = rs1;  cmd_rs2_i = rs2; cmd_rd_i = rd;  cmd_data_i = dat;
        for (int k = 0; k < 100 && !taken; k++) begin
            @(negedge clk_i);
            acc = cmd_ready_o;
            @(posedge clk_i);
            #1;
            if (acc) begin
                e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.op = op; e.flag = fl;
                e.mux = !ld; e.data = dat;
                e.exp_cyc = (rel >= 0) ? cyc + rel : -1;
                e.gap = gap;
                exp_q.push_back(e);
                taken = 1'b1;
            end
        end
        check("send_accepted", taken, 1);
    endtask

    task automatic wait_idle(input int budget);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk_i);
            if (!busy_o) seen = 1'b1;
        end
        check("drain_to_idle", seen, 1);
    endtask

    // Monitor: compares every write against the head of the expected queue.
    initial begin : monitor
        exp_t e;
        bit   prev_we;
        int   last_we;
        int   model_cnt;
        prev_we = 1'b0; last_we = 0; model_cnt = 0;
        forever begin
            @(negedge clk_i);
            if (reset_i) begin
                exp_q.delete();
                model_cnt = 0;
                prev_we = 1'b0;
                continue;
            end
            check("done_matches_we", done_o, we_o);
            if (we_o) begin
                check("we_single_cycle", prev_we, 0);
                check("write_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("write_fields",
                          {addr_rs1_o, addr_rs2_o, addr_rd_o, alucont_o, flag_o, mux_o, data_o},
                          {e.rs1, e.rs2, e.rd, e.op, e.flag, e.mux, e.data});
                    check("count_during_write", count_o, model_cnt[7:0]);
                    if (e.exp_cyc >= 0) check("write_latency", cyc, e.exp_cyc);
                    if (e.gap > 0) check("write_gap", cyc - last_we, e.gap);
                    model_cnt++;
                end
                last_we = cyc;
            end
            prev_we = we_o;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "bench did not finish");
    end

    initial begin : stimulus
        // Reset state
        repeat (3) @(negedge clk_i);
        check("reset_ready", cmd_ready_o, 1);
        check("reset_busy", busy_o, 0);
        check("reset_we", we_o, 0);
        check("reset_count", count_o, 0);
        check("reset_datapath", {addr_rs1_o, addr_rs2_o, addr_rd_o, alucont_o, flag_o, mux_o, data_o}, 0);
        reset_i = 1'b0;
        sync();

        // Single ALU op: IDLE, then addresses held through FETCH/EXEC/WRITE, write in 4th cycle
        send(1'b0, 4'h2, 1'b0, 5'd3, 5'd4, 5'd5, 16'h0000, 3, 0);
        cmd_valid_i = 1'b0;
        @(negedge clk_i);
        check("alu_idle_cycle_busy", busy_o, 1);
        check("alu_idle_cycle_addr", {addr_rs1_o, addr_rs2_o, addr_rd_o}, 0);
        @(negedge clk_i);
        check("alu_fetch_addr", {addr_rs1_o, addr_rs2_o, addr_rd_o}, {5'd3, 5'd4, 5'd5});
        check("alu_fetch_ctrl", {alucont_o, mux_o, we_o}, {4'h2, 1'b1, 1'b0});
        @(negedge clk_i);
        check("alu_exec_addr", {addr_rs1_o, addr_rs2_o, addr_rd_o}, {5'd3, 5'd4, 5'd5});
        check("alu_exec_we", we_o, 0);
        @(negedge clk_i);
        @(negedge clk_i);
        check("alu_count", count_o, 1);
        check("alu_back_idle", {busy_o, addr_rs1_o, addr_rd_o, mux_o}, 0);

        // Single load: FETCH then WRITE, mux 0, data 16'hBEEF
        sync();
        send(1'b1, 4'hF, 1'b1, 5'd1, 5'd2, 5'd7, 16'hBEEF, 2, 0);
        cmd_valid_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        check("load_fetch_mux_data", {mux_o, data_o}, {1'b0, 16'hBEEF});
        wait_idle(10);
        check("load_count", count_o, 2);

        // Six ALU ops with valid held: FIFO fills to 4, all retire 3 cycles apart
        sync();
        for (int i = 0; i < 6; i++) begin
            send(1'b0, 4'(i + 1), 1'(i), 5'(i + 1), 5'(i + 10), 5'(i + 20),
                 16'hA000 + 16'(i), (i == 0) ? 3 : -1, (i == 0) ? 0 : 3);
        end
        check("ready_low_when_full", cmd_ready_o, 0);
        cmd_valid_i = 1'b0;
        wait_idle(60);
        check("burst_count", count_o, 8);

        // Push onto a one-entry FIFO on the same edge the idle FSM pops it
        sync();
        send(1'b1, 4'h0, 1'b0, 5'd0, 5'd0, 5'd9, 16'h1234, 2, 0);
        send(1'b0, 4'h7, 1'b1, 5'd11, 5'd12, 5'd13, 16'h0000, -1, 3);
        cmd_valid_i = 1'b0;
        wait_idle(30);
        check("push_pop_count", count_o, 10);
        check("push_pop_drained", exp_q.size(), 0);

        // Reset during EXEC of a queued ALU op aborts it with no write
        sync();
        send(1'b0, 4'h3, 1'b0, 5'd1, 5'd2, 5'd3, 16'h0000, -1, 0);
        send(1'b0, 4'h4, 1'b0, 5'd4, 5'd5, 5'd6, 16'h0000, -1, 0);
        cmd_valid_i = 1'b0;
        sync();
        reset_i = 1'b1;
        #1;
        check("abort_we", we_o, 0);
        check("abort_ready", cmd_ready_o, 1);
        check("abort_busy", busy_o, 0);
        check("abort_count", count_o, 0);
        check("abort_rd", addr_rd_o, 0);
        repeat (2) @(negedge clk_i);
        reset_i = 1'b0;
        repeat (10) @(negedge clk_i);
        check("abort_stays_idle", {busy_o, count_o}, 0);

        // 256 loads: count reads 255 during the last write, 0 afterwards
        sync();
        for (int i = 0; i < 256; i++) begin
            send(1'b1, 4'h0, 1'b0, 5'(i), 5'(i + 1), 5'(i + 2), 16'h5000 + 16'(i),
                 (i == 0) ? 2 : -1, (i == 0) ? 0 : 2);
        end
        cmd_valid_i = 1'b0;
        wait_idle(200);
        check("count_wrap", count_o, 0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
